// File: rtl/game_clock_score_if.sv
// Event pulses from game logic and display-ready results back from game_clock_score.
interface game_clock_score_if;
    logic       start;
    logic       pause;
    logic       score_inc;
    logic       miss;
    logic [6:0] score;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       game_over;
    logic       sec_tick;

    modport master (
        output start, pause, score_inc, miss,
        input  score, sec_tens, sec_ones, running, game_over, sec_tick
    );

    modport slave (
        input  start, pause, score_inc, miss,
        output score, sec_tens, sec_ones, running, game_over, sec_tick
    );
endinterface

// File: rtl/game_clock_score.sv
// Game run-state: BCD countdown timer and saturating score with registered outputs.
// Optional GAME_CLOCK_BONUS_TIME_EN: +5 s on every score that reaches a nonzero multiple of 10.
module game_clock_score #(
    parameter int TICK_DIV   = 100000000,
    parameter int START_SECS = 30,
    parameter int MAX_SCORE  = 99
) (
    input  logic               clk,
    input  logic               rst,
    game_clock_score_if.slave  bus
);
    localparam int               DIV_W      = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [3:0]       START_TENS = 4'(START_SECS / 10);
    localparam logic [3:0]       START_ONES = 4'(START_SECS % 10);
    localparam logic [6:0]       SCORE_MAX  = 7'(MAX_SCORE);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, OVER} state_e;

    state_e           state_q, state_d;
    logic [6:0]       score_q, score_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       ones_q, ones_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             running_q, running_d;
    logic             game_over_q, game_over_d;
    logic             sec_tick_q, sec_tick_d;
    logic             load;

    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        div_d      = div_q;
        sec_tick_d = 1'b0;
        load       = 1'b0;

        case (state_q)
            IDLE, OVER: begin
                load = bus.start;
            end
            RUN: begin
                if (div_q == DIV_LAST) begin
                    div_d      = '0;
                    sec_tick_d = 1'b1;
                    if (ones_q != 4'd0) begin
                        ones_d = ones_q - 4'd1;
                    end else begin
                        ones_d = 4'd9;
                        tens_d = tens_q - 4'd1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
                // score_inc is accepted even when the same edge ends or pauses the game
                if (bus.score_inc && (score_q < SCORE_MAX)) begin
                    score_d = score_q + 7'd1;
`ifdef GAME_CLOCK_BONUS_TIME_EN
                    if ((score_d % 7'd10) == 7'd0) begin
                        if ((tens_d == 4'd9) && (ones_d >= 4'd5)) begin
                            ones_d = 4'd9;
                        end else if (ones_d >= 4'd5) begin
                            ones_d = ones_d - 4'd5;
                            tens_d = tens_d + 4'd1;
                        end else begin
                            ones_d = ones_d + 4'd5;
                        end
                    end
`endif
                end
                if (bus.miss || ((tens_d == 4'd0) && (ones_d == 4'd0))) begin
                    state_d = OVER;
                end else if (bus.pause) begin
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (bus.miss) begin
                    state_d = OVER;
                end else if (bus.pause) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d = RUN;
            score_d = 7'd0;
            tens_d  = START_TENS;
            ones_d  = START_ONES;
            div_d   = '0;
        end

        running_d   = (state_d == RUN);
        game_over_d = (state_d == OVER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            score_q     <= 7'd0;
            tens_q      <= START_TENS;
            ones_q      <= START_ONES;
            div_q       <= '0;
            running_q   <= 1'b0;
            game_over_q <= 1'b0;
            sec_tick_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            div_q       <= div_d;
            running_q   <= running_d;
            game_over_q <= game_over_d;
            sec_tick_q  <= sec_tick_d;
        end
    end

    assign bus.score     = score_q;
    assign bus.sec_tens  = tens_q;
    assign bus.sec_ones  = ones_q;
    assign bus.running   = running_q;
    assign bus.game_over = game_over_q;
    assign bus.sec_tick  = sec_tick_q;
endmodule
